countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 166 ++++++++++++++++
 tb/tb_countdown_timer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Seconds countdown timer with prescaler, pause, one-shot/auto-reload modes.
// Optional warning flag enabled by defining COUNTDOWN_TIMER_WARN_EN.
module countdown_timer #(
  parameter int SYS_FREQ = 50000000,
  parameter int WIDTH    = 5,
  parameter int WARN_SEC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             time_f,
  input  logic [WIDTH-1:0] time_v,
  input  logic             reload_f,
  input  logic             pause_f,
  output logic [WIDTH-1:0] timeleft,
  output logic             end_f,
  output logic             end_p,
  output logic             sec_p,
  output logic             busy,
  output logic             warn_f
);

  localparam int            TW       = $clog2(SYS_FREQ);
  localparam logic [TW-1:0] TICK_MAX = TW'(SYS_FREQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state_r;
  logic [TW-1:0]    ticks_r;
  logic             mode_r;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] timeleft_r;
  logic             end_f_r;
  logic             end_p_r;
  logic             sec_p_r;
  logic             busy_r;

  logic             count_s;
  logic             wrap_s;
  logic             last_s;
  logic [WIDTH-1:0] tl_nxt_s;

  // Counting happens in RUN, and also on the edge that leaves PAUSED
  assign count_s = ((state_r == RUN) || (state_r == PAUSED)) && !pause_f;
  assign wrap_s  = count_s && (ticks_r == TICK_MAX);
  assign last_s  = wrap_s && (timeleft_r == WIDTH'(1'b1));

  // Next remaining-seconds value, shared by the timeleft and warning registers
  always_comb begin
    tl_nxt_s = timeleft_r;
    if (time_f) begin
      tl_nxt_s = time_v;
    end else if (last_s) begin
      if (mode_r) begin
        tl_nxt_s = reload_r;
      end else begin
        tl_nxt_s = {WIDTH{1'b0}};
      end
    end else if (wrap_s) begin
      tl_nxt_s = timeleft_r - WIDTH'(1'b1);
    end else begin
      tl_nxt_s = timeleft_r;
    end
  end

  // Main state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ticks_r    <= {TW{1'b0}};
      mode_r     <= 1'b0;
      reload_r   <= {WIDTH{1'b0}};
      timeleft_r <= {WIDTH{1'b0}};
      end_f_r    <= 1'b0;
      end_p_r    <= 1'b0;
      sec_p_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      end_p_r    <= 1'b0;
      sec_p_r    <= 1'b0;
      timeleft_r <= tl_nxt_s;
      if (time_f) begin
        ticks_r  <= {TW{1'b0}};
        mode_r   <= reload_f;
        reload_r <= time_v;
        if (time_v != {WIDTH{1'b0}}) begin
          state_r <= RUN;
          end_f_r <= 1'b0;
          busy_r  <= 1'b1;
        end else begin
          state_r <= EXPIRED;
          end_f_r <= 1'b1;
          end_p_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      end else begin
        case (state_r)
          IDLE: begin
            ticks_r <= {TW{1'b0}};
          end
          RUN, PAUSED: begin
            if (pause_f) begin
              state_r <= PAUSED;
            end else if (wrap_s) begin
              ticks_r <= {TW{1'b0}};
              sec_p_r <= 1'b1;
              if (last_s) begin
                end_p_r <= 1'b1;
                if (mode_r) begin
                  state_r <= RUN;
                end else begin
                  state_r <= EXPIRED;
                  end_f_r <= 1'b1;
                  busy_r  <= 1'b0;
                end
              end else begin
                state_r <= RUN;
              end
            end else begin
              ticks_r <= ticks_r + TW'(1'b1);
              state_r <= RUN;
            end
          end
          EXPIRED: begin
            ticks_r <= {TW{1'b0}};
          end
          default: begin
            state_r <= IDLE;
            ticks_r <= {TW{1'b0}};
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef COUNTDOWN_TIMER_WARN_EN
  localparam logic [31:0] WARN_V = 32'(WARN_SEC);

  logic warn_f_r;

  // A nonzero timeleft only exists in RUN/PAUSED, so the value alone decides
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warn_f_r <= 1'b0;
    end else begin
      warn_f_r <= (tl_nxt_s != {WIDTH{1'b0}}) && (32'(tl_nxt_s) <= WARN_V);
    end
  end

  assign warn_f = warn_f_r;
`else
  assign warn_f = 1'b0;
`endif

  assign timeleft = timeleft_r;
  assign end_f    = end_f_r;
  assign end_p    = end_p_r;
  assign sec_p    = sec_p_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed, table-driven bench for countdown_timer (SYS_FREQ=50, WIDTH=5, WARN_SEC=3).
module tb_countdown_timer;

  localparam int SYS_FREQ = 50;
  localparam int WIDTH    = 5;
  localparam int WARN_SEC = 3;
`ifdef COUNTDOWN_TIMER_WARN_EN
  localparam logic WARN_ON = 1'b1;
`else
  localparam logic WARN_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             time_f;
  logic [WIDTH-1:0] time_v;
  logic             reload_f;
  logic             pause_f;
  logic [WIDTH-1:0] timeleft;
  logic             end_f;
  logic             end_p;
  logic             sec_p;
  logic             busy;
  logic             warn_f;

  countdown_timer #(
    .SYS_FREQ (SYS_FREQ),
    .WIDTH    (WIDTH),
    .WARN_SEC (WARN_SEC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .time_f   (time_f),
    .time_v   (time_v),
    .reload_f (reload_f),
    .pause_f  (pause_f),
    .timeleft (timeleft),
    .end_f    (end_f),
    .end_p    (end_p),
    .sec_p    (sec_p),
    .busy     (busy),
    .warn_f   (warn_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // n clock edges; time_f is a strobe, so it drops after the first one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      time_f = 1'b0;
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] tl, input logic ef,
                            input logic ep, input logic sp, input logic bz, input logic wn);
    chk({tag, ".timeleft"}, 32'(timeleft), 32'(tl));
    chk({tag, ".end_f"},    32'(end_f),    32'(ef));
    chk({tag, ".end_p"},    32'(end_p),    32'(ep));
    chk({tag, ".sec_p"},    32'(sec_p),    32'(sp));
    chk({tag, ".busy"},     32'(busy),     32'(bz));
    chk({tag, ".warn_f"},   32'(warn_f),   32'(wn & WARN_ON));
  endtask

  typedef struct {
    string      name;
    logic       tf;
    logic [4:0] tv;
    logic       rl;
    logic       pz;
    int         n;
    logic [4:0] tl;
    logic       endf;
    logic       endp;
    logic       secp;
    logic       busy;
    logic       warn;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  int         secs;
  logic [4:0] exp_tl;

  initial begin
    // name, time_f, time_v, reload_f, pause_f, edges, timeleft, end_f, end_p, sec_p, busy, warn
    vecs[0]  = '{"os_load",    1'b1, 5'd5, 1'b0, 1'b0,   1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{"os_e49",     1'b0, 5'd5, 1'b0, 1'b0,  49, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{"os_e50",     1'b0, 5'd5, 1'b0, 1'b0,   1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{"os_e51",     1'b0, 5'd5, 1'b0, 1'b0,   1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"os_e100",    1'b0, 5'd5, 1'b0, 1'b0,  49, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{"os_e200",    1'b0, 5'd5, 1'b0, 1'b0, 100, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{"os_e249",    1'b0, 5'd5, 1'b0, 1'b0,  49, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{"os_e250",    1'b0, 5'd5, 1'b0, 1'b0,   1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{"os_e251",    1'b0, 5'd5, 1'b0, 1'b0,   1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"exp_ignore", 1'b0, 5'd9, 1'b1, 1'b0,  20, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{"zero_load",  1'b1, 5'd0, 1'b0, 1'b0,   1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{"zero_after", 1'b0, 5'd0, 1'b0, 1'b0,   1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{"ar_load",    1'b1, 5'd2, 1'b1, 1'b0,   1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{"ar_e50",     1'b0, 5'd2, 1'b1, 1'b0,  50, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{"ar_e100",    1'b0, 5'd2, 1'b1, 1'b0,  50, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{"ar_e101",    1'b0, 5'd2, 1'b1, 1'b0,   1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{"ar_e200",    1'b0, 5'd2, 1'b1, 1'b0,  99, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{"ar_e500",    1'b0, 5'd2, 1'b1, 1'b0, 300, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[18] = '{"ar_ignore",  1'b0, 5'd7, 1'b0, 1'b0, 100, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[19] = '{"rl_load4",   1'b1, 5'd4, 1'b0, 1'b0,  40, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{"rl_load7",   1'b1, 5'd7, 1'b0, 1'b0,   1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[21] = '{"rl_e89",     1'b0, 5'd7, 1'b0, 1'b0,  49, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[22] = '{"rl_e90",     1'b0, 5'd7, 1'b0, 1'b0,   1, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[23] = '{"pri_load3",  1'b1, 5'd3, 1'b0, 1'b0,  50, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[24] = '{"pri_reload", 1'b1, 5'd5, 1'b0, 1'b0,   1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n    = 1'b0;
    time_f   = 1'b0;
    time_v   = 5'd0;
    reload_f = 1'b0;
    pause_f  = 1'b0;

    // Reset state, then stays idle after release without a load
    #12;
    check_outs("rst", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    time_v = 5'd6;
    tick(10);
    check_outs("idle", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      time_f   = vecs[i].tf;
      time_v   = vecs[i].tv;
      reload_f = vecs[i].rl;
      pause_f  = vecs[i].pz;
      tick(vecs[i].n);
      check_outs(vecs[i].name, vecs[i].tl, vecs[i].endf, vecs[i].endp,
                 vecs[i].secp, vecs[i].busy, vecs[i].warn);
    end

    // Pause sampled on edges 20..119: no sec_p, first decrement at edge 150
    time_f   = 1'b1;
    time_v   = 5'd5;
    reload_f = 1'b0;
    pause_f  = 1'b0;
    secs     = 0;
    for (int e = 0; e <= 150; e++) begin
      @(posedge clk);
      #1;
      time_f = 1'b0;
      if (e >= 1 && e < 150) secs += int'(sec_p);
      if (e == 19) pause_f = 1'b1;
      if (e == 119) pause_f = 1'b0;
      if (e == 60) chk("pz_busy", 32'(busy), 32'd1);
      if (e == 149) chk("pz_tl149", 32'(timeleft), 32'd5);
    end
    chk("pz_secp_count", 32'(secs), 32'd0);
    chk("pz_e150_secp", 32'(sec_p), 32'd1);
    chk("pz_e150_tl", 32'(timeleft), 32'd4);

    // Warning window during a one-shot run, then reset abandons the count
    time_f = 1'b1;
    time_v = 5'd5;
    for (int e = 0; e < 120; e++) begin
      tick(1);
      exp_tl = 5'd5 - 5'(e / SYS_FREQ);
      chk("rc_tl", 32'(timeleft), 32'(exp_tl));
      chk("rc_warn", 32'(warn_f), 32'(WARN_ON & (exp_tl <= 5'd3) & (exp_tl != 5'd0)));
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("rc_async", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    @(negedge clk);
    rst_n    = 1'b1;
    time_v   = 5'd9;
    reload_f = 1'b1;
    tick(60);
    check_outs("rc_idle", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
